// File: rtl/multicycle_control.sv
// Main control FSM of a multi-cycle RV32I core.
// Sequences each instruction through fetch/decode/execute/memory/writeback and
// drives datapath mux selects, write enables and the ALU-control request.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FETCH     | read instruction at PC, latch IR/old PC, PC <= PC+4 on ready
// DECODE    | read registers, compute branch/JAL target into ALUOut
// MEM_ADDR  | compute load/store address rs1+imm
// MEM_READ  | load data access, wait for memory ready
// MEM_WB    | write load data to register file
// MEM_WRITE | store access, strobe held until memory ready
// EXEC_R    | register-register ALU op
// EXEC_I    | register-immediate ALU op
// ALU_WB    | write ALUOut to register file
// BRANCH    | compare rs1/rs2, load PC with target when taken
// JAL       | PC <= target already in ALUOut
// JALR      | PC <= rs1+imm
// LINK      | rd <= old PC + 4
// LUI       | ALU computes 0 + imm
// AUIPC     | ALU computes old PC + imm
module multicycle_control #(
    parameter logic ALU_CTRL_ADD = 1'b0,
    parameter logic ALU_CTRL_OP  = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       alu_zero_i,
    input  logic       alu_lsb_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       adr_src_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic       alu_ctrl_o,
    output logic       illegal_instr_o,
    output logic [3:0] state_dbg_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_LINK      = 4'd12,
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    state_t state_q, state_d;
    logic   take;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Branch outcome from funct3; SLT/SLTU result bit drives the ordered compares.
    always_comb begin
        take = 1'b0;
        case (funct3_i)
            3'b000:          take = alu_zero_i;
            3'b001:          take = ~alu_zero_i;
            3'b100, 3'b110:  take = alu_lsb_i;
            3'b101, 3'b111:  take = ~alu_lsb_i;
            default:         take = 1'b0;
        endcase
    end

    // Next state and datapath controls; reset overrides every write enable.
    always_comb begin
        state_d         = state_q;
        pc_write_o      = 1'b0;
        adr_src_o       = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        result_src_o    = 2'b00;
        alu_src_a_o     = 2'b00;
        alu_src_b_o     = 2'b00;
        alu_ctrl_o      = ALU_CTRL_ADD;
        illegal_instr_o = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    OP_FENCE:          state_d = S_FETCH;
                    default: begin
                        state_d         = S_FETCH;
                        illegal_instr_o = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = (opcode_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src_o = 2'b01;
                reg_write_o  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src_o   = 1'b1;
                mem_write_o = 1'b1;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a_o = 2'b10;
                alu_ctrl_o  = ALU_CTRL_OP;
                state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_ctrl_o  = ALU_CTRL_OP;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_o = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = 2'b10;
                alu_ctrl_o  = ALU_CTRL_OP;
                pc_write_o  = take;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                pc_write_o = 1'b1;
                state_d    = S_LINK;
            end
            S_JALR: begin
                alu_src_a_o  = 2'b10;
                alu_src_b_o  = 2'b01;
                result_src_o = 2'b10;
                pc_write_o   = 1'b1;
                state_d      = S_LINK;
            end
            S_LINK: begin
                alu_src_a_o  = 2'b01;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                reg_write_o  = 1'b1;
                state_d      = S_FETCH;
            end
            S_LUI: begin
                alu_src_a_o = 2'b11;
                alu_src_b_o = 2'b01;
                state_d     = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                state_d     = S_ALU_WB;
            end
            default: state_d = S_FETCH;
        endcase

        if (rst_i) begin
            pc_write_o      = 1'b0;
            ir_write_o      = 1'b0;
            mem_write_o     = 1'b0;
            reg_write_o     = 1'b0;
            illegal_instr_o = 1'b0;
            state_d         = S_FETCH;
        end
    end

    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each cycle's expected control word is
// queued when the inputs are driven and popped/compared mid-cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero, alu_lsb, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic       alu_ctrl, illegal_instr;
    logic [3:0] state_dbg;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [16:0] exp;
    } sb_entry_t;
    sb_entry_t sb_q[$];

    localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4,
                   MEM_WRITE = 5, EXEC_R = 6, EXEC_I = 7, ALU_WB = 8, BRANCH = 9,
                   JAL = 10, JALR = 11, LINK = 12, LUI = 13, AUIPC = 14;

    multicycle_control dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .opcode_i       (opcode),
        .funct3_i       (funct3),
        .alu_zero_i     (alu_zero),
        .alu_lsb_i      (alu_lsb),
        .mem_ready_i    (mem_ready),
        .pc_write_o     (pc_write),
        .adr_src_o      (adr_src),
        .mem_write_o    (mem_write),
        .ir_write_o     (ir_write),
        .reg_write_o    (reg_write),
        .result_src_o   (result_src),
        .alu_src_a_o    (alu_src_a),
        .alu_src_b_o    (alu_src_b),
        .alu_ctrl_o     (alu_ctrl),
        .illegal_instr_o(illegal_instr),
        .state_dbg_o    (state_dbg)
    );

    always #5 clk = ~clk;

    // {state, pc_write, adr_src, mem_write, ir_write, reg_write, result_src, a, b, alu_ctrl, illegal}
    function automatic logic [16:0] ev(int st, bit pw, bit adr, bit mw, bit irw, bit rw,
                                       logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                       bit ac, bit ill);
        logic [3:0] s4;
        s4 = st[3:0];
        return {s4, pw, adr, mw, irw, rw, rs, a, b, ac, ill};
    endfunction

    // Expected control word for a state outside reset; flag = mem_ready in FETCH,
    // branch taken in BRANCH, illegal opcode in DECODE.
    function automatic logic [16:0] es(int st, bit flag);
        case (st)
            FETCH:     return ev(FETCH,     flag, 0, 0, flag, 0, 2'b10, 2'b00, 2'b10, 0, 0);
            DECODE:    return ev(DECODE,    0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, flag);
            MEM_ADDR:  return ev(MEM_ADDR,  0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 0);
            MEM_READ:  return ev(MEM_READ,  0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
            MEM_WB:    return ev(MEM_WB,    0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 0, 0);
            MEM_WRITE: return ev(MEM_WRITE, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
            EXEC_R:    return ev(EXEC_R,    0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 1, 0);
            EXEC_I:    return ev(EXEC_I,    0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 1, 0);
            ALU_WB:    return ev(ALU_WB,    0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0);
            BRANCH:    return ev(BRANCH,    flag, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 1, 0);
            JAL:       return ev(JAL,       1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
            JALR:      return ev(JALR,      1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 0, 0);
            LINK:      return ev(LINK,      0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 0, 0);
            LUI:       return ev(LUI,       0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 0, 0);
            AUIPC:     return ev(AUIPC,     0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 0);
            default:   return '0;
        endcase
    endfunction

    // Queue one expectation for the current cycle, compare it mid-cycle, advance.
    task automatic cyc(string tag, logic [16:0] exp);
        sb_entry_t e;
        logic [16:0] obs;
        sb_q.push_back('{tag: tag, exp: exp});
        @(negedge clk);
        e = sb_q.pop_front();
        obs = {state_dbg, pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_ctrl, illegal_instr};
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr(string tag, logic [6:0] op, logic [2:0] f3, bit az, bit al);
        opcode   = op;
        funct3   = f3;
        alu_zero = az;
        alu_lsb  = al;
        mem_ready = 1'b1;
        cyc({tag, "_fetch"}, es(FETCH, 1));
        cyc({tag, "_decode"}, es(DECODE, 0));
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011; funct3 = 3'b000;
        alu_zero = 1'b0; alu_lsb = 1'b0;
        @(posedge clk);
        #1;
        // reset: FETCH-decoded selects but every enable held low
        cyc("reset_c1", ev(FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 0));
        cyc("reset_c2", ev(FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 0));
        rst = 1'b0;

        // ADD
        instr("add", 7'b0110011, 3'b000, 0, 0);
        cyc("add_exec", es(EXEC_R, 0));
        cyc("add_wb", es(ALU_WB, 0));

        // ADDI, preceded by a fetch wait
        mem_ready = 1'b0;
        cyc("fetch_wait", es(FETCH, 0));
        instr("addi", 7'b0010011, 3'b000, 0, 0);
        cyc("addi_exec", es(EXEC_I, 0));
        cyc("addi_wb", es(ALU_WB, 0));

        // LW with three memory wait cycles
        instr("lw", 7'b0000011, 3'b010, 0, 0);
        cyc("lw_addr", es(MEM_ADDR, 0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_wait", es(MEM_READ, 0));
        mem_ready = 1'b1;
        cyc("lw_read", es(MEM_READ, 0));
        cyc("lw_wb", es(MEM_WB, 0));

        // SW, no wait
        instr("sw", 7'b0100011, 3'b010, 0, 0);
        cyc("sw_addr", es(MEM_ADDR, 0));
        cyc("sw_write", es(MEM_WRITE, 0));

        // branches: {funct3, alu_zero, alu_lsb, taken}
        instr("bne_t", 7'b1100011, 3'b001, 0, 0);
        cyc("bne_t_br", es(BRANCH, 1));
        instr("bne_n", 7'b1100011, 3'b001, 1, 0);
        cyc("bne_n_br", es(BRANCH, 0));
        instr("beq_t", 7'b1100011, 3'b000, 1, 0);
        cyc("beq_t_br", es(BRANCH, 1));
        instr("blt_t", 7'b1100011, 3'b100, 0, 1);
        cyc("blt_t_br", es(BRANCH, 1));
        instr("bgeu_n", 7'b1100011, 3'b111, 0, 1);
        cyc("bgeu_n_br", es(BRANCH, 0));
        instr("bge_t", 7'b1100011, 3'b101, 1, 0);
        cyc("bge_t_br", es(BRANCH, 1));
        instr("f010_n", 7'b1100011, 3'b010, 1, 1);
        cyc("f010_n_br", es(BRANCH, 0));

        // jumps
        instr("jal", 7'b1101111, 3'b000, 0, 0);
        cyc("jal_jump", es(JAL, 0));
        cyc("jal_link", es(LINK, 0));
        instr("jalr", 7'b1100111, 3'b000, 0, 0);
        cyc("jalr_jump", es(JALR, 0));
        cyc("jalr_link", es(LINK, 0));

        // upper immediates
        instr("lui", 7'b0110111, 3'b000, 0, 0);
        cyc("lui_exec", es(LUI, 0));
        cyc("lui_wb", es(ALU_WB, 0));
        instr("auipc", 7'b0010111, 3'b000, 0, 0);
        cyc("auipc_exec", es(AUIPC, 0));
        cyc("auipc_wb", es(ALU_WB, 0));

        // FENCE as NOP, then illegal opcode pulse
        instr("fence", 7'b0001111, 3'b000, 0, 0);
        opcode = 7'b1111111;
        cyc("ill_fetch", es(FETCH, 1));
        cyc("ill_decode", es(DECODE, 1));
        mem_ready = 1'b0;
        cyc("ill_after", es(FETCH, 0));

        // SW stalled, then reset abandons the store
        instr("sw_rst", 7'b0100011, 3'b010, 0, 0);
        cyc("sw_rst_addr", es(MEM_ADDR, 0));
        mem_ready = 1'b0;
        cyc("sw_rst_wait1", es(MEM_WRITE, 0));
        cyc("sw_rst_wait2", es(MEM_WRITE, 0));
        rst = 1'b1;
        cyc("sw_rst_reset", ev(MEM_WRITE, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        rst = 1'b0;
        mem_ready = 1'b1;
        cyc("sw_rst_fetch", es(FETCH, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the multi-cycle RV32I core.
- Sequences every instruction through fetch, decode, execute, memory and writeback steps.
- Drives the datapath muxes and write enables, and drives `alu_ctrl` into the ALU op decoder: ADD when forced, OP when the decoder should derive the op from `funct3`/`funct7`.
- Stalls on a single-bit memory ready handshake.

Parameters:
- ALU_CTRL_ADD, 1'b0, force ALU op ADD
- ALU_CTRL_OP, 1'b1, ALU op from instruction fields

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instruction register [6:0]
- funct3  in  3  instruction register [14:12]
- alu_zero  in  1  ALU result == 0
- alu_lsb  in  1  ALU result bit 0 (SLT/SLTU outcome)
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  load PC from result bus
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut register
- mem_write  out  1  store strobe
- ir_write  out  1  latch instruction register and old-PC register
- reg_write  out  1  register file write
- result_src  out  2  00 = ALUOut register, 01 = memory data, 10 = ALU result
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1, 11 = zero
- alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4
- alu_ctrl  out  1  ALU_CTRL_ADD / ALU_CTRL_OP
- illegal_instr  out  1  one-cycle pulse, unknown opcode
- state_dbg  out  4  current state encoding

Behaviour:
- Moore outputs decoded from state. Exceptions, which also depend on inputs:
  - `pc_write`/`ir_write` in FETCH
  - `pc_write` in BRANCH
  - `illegal_instr` in DECODE
- Unlisted outputs are 0. `alu_ctrl` defaults to ADD.
- Reset: while `rst` is high, `pc_write`, `ir_write`, `mem_write`, `reg_write` and `illegal_instr` are forced 0. Next state is FETCH (encoding 0). `rst` mid-instruction abandons it, including a pending store.

States, with outputs and transitions:
- FETCH: adr_src=0, a=00, b=10, ADD, result_src=10.
  - Holds until `mem_ready`.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1 (PC+4), next DECODE.
- DECODE: a=01, b=01, ADD (branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 / 0100011 → MEM_ADDR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - 0001111 (FENCE) → FETCH as a NOP
  - any other opcode → FETCH with `illegal_instr`=1
- MEM_ADDR: a=10, b=01, ADD. Next MEM_READ if opcode is 0000011, else MEM_WRITE.
- MEM_READ: adr_src=1. Holds until `mem_ready`, then MEM_WB.
- MEM_WB: result_src=01, reg_write=1 → FETCH.
- MEM_WRITE: adr_src=1, mem_write=1, held until `mem_ready`. Completes in the `mem_ready` cycle → FETCH.
- EXEC_R: a=10, b=00, alu_ctrl=OP → ALU_WB.
- EXEC_I: a=10, b=01, alu_ctrl=OP → ALU_WB.
- ALU_WB: result_src=00, reg_write=1 → FETCH.
- BRANCH: a=10, b=00, alu_ctrl=OP, result_src=00. `pc_write` = take → FETCH. `take` by `funct3`:
  - 000: alu_zero
  - 001: !alu_zero
  - 100 / 110: alu_lsb
  - 101 / 111: !alu_lsb
  - 010 / 011: 0
- JAL: result_src=00, pc_write=1 → LINK.
- JALR: a=10, b=01, ADD, result_src=10, pc_write=1 → LINK. The datapath clears bit 0 of the target.
- LINK: a=01, b=10, ADD, result_src=10, reg_write=1 → FETCH.
- LUI: a=11, b=01, ADD → ALU_WB.
- AUIPC: a=01, b=01, ADD → ALU_WB.

Cycle counts with `mem_ready` tied to 1:

| Instruction | Cycles |
|---|---|
| R / I / LUI / AUIPC | 4 |
| Load | 5 |
| Store | 4 |
| Branch | 3 |
| JAL / JALR | 4 |

Each memory wait cycle adds 1.

Test Plan:
- `rst`=1 for 2 cycles with `mem_ready`=1 → all write enables 0 during reset. First post-reset cycle: state_dbg=0, ir_write=1, pc_write=1.
- ADD (opcode 0110011), mem_ready=1 → states FETCH, DECODE, EXEC_R, ALU_WB. alu_ctrl=1 only in EXEC_R. reg_write=1 only in ALU_WB with result_src=00.
- LW, mem_ready low for 3 cycles in MEM_READ → FSM holds MEM_READ with adr_src=1, then MEM_WB with reg_write=1, result_src=01. Total 8 cycles.
- BNE (funct3=001), alu_zero=0 → pc_write=1 in BRANCH. Repeat with alu_zero=1 → pc_write=0. Both return to FETCH after 3 cycles.
- JALR → JALR state: pc_write=1, result_src=10. LINK state: a=01, b=10, reg_write=1. Opcode 1111111 → illegal_instr pulses exactly 1 cycle in DECODE, next state FETCH.
- SW with mem_ready=0, then `rst` asserted in MEM_WRITE → mem_write drops in the reset cycle, state FETCH on the next edge.
